// File: rtl/ux607_regvec_wr_sched.sv
// ---------------------------------------------------------------------------
// ux607_regvec_wr_sched
//
// Write scheduler for a bank of NUM_REGS register vectors (DW bits each).
// Two requesters share the bank's io_d bus and per-vector io_en strobes:
//   bus : peripheral register-file port, masked writes (read-modify-write
//         against the vector's current io_q)
//   hw  : internal logic, full-word writes
// Grant is round-robin between the two. Each write takes three cycles:
// IDLE (accept) -> COMMIT (drive reg_d/reg_en) -> DONE (report) -> IDLE.
//
// Ports
//   clock, reset              clock; asynchronous active-low reset
//   bus_valid/ready/addr/data/mask   bus write request
//   hw_valid/ready/addr/data         hw write request (mask = all ones)
//   reg_q                     concatenated io_q of all vectors, vector 0 in LSBs
//   reg_d, reg_en             shared io_d and one-hot io_en to the bank
//   done, done_src, done_err  one-cycle completion pulse, source (1 = hw),
//                             and dropped-write flag
//   busy                      scheduler is not idle
//   lock_set, lock_addr       sticky per-vector write lock for bus writes
//                             (present only with UX607_REGVEC_LOCK_EN)
//
// Build option: define UX607_REGVEC_LOCK_EN to add the lock register and
// its ports. Without it done_err reports only out-of-range addresses.
// ---------------------------------------------------------------------------
module ux607_regvec_wr_sched #(
  parameter int NUM_REGS = 4,
  parameter int DW       = 20,
  parameter int AW       = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   bus_valid,
  output logic                   bus_ready,
  input  logic [AW-1:0]          bus_addr,
  input  logic [DW-1:0]          bus_data,
  input  logic [DW-1:0]          bus_mask,
  input  logic                   hw_valid,
  output logic                   hw_ready,
  input  logic [AW-1:0]          hw_addr,
  input  logic [DW-1:0]          hw_data,
`ifdef UX607_REGVEC_LOCK_EN
  input  logic                   lock_set,
  input  logic [AW-1:0]          lock_addr,
`endif
  input  logic [NUM_REGS*DW-1:0] reg_q,
  output logic [DW-1:0]          reg_d,
  output logic [NUM_REGS-1:0]    reg_en,
  output logic                   done,
  output logic                   done_src,
  output logic                   done_err,
  output logic                   busy
);

  localparam logic [AW:0] NUM_REGS_W = (AW+1)'(NUM_REGS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state;
  logic                hold_src;   // 0 = bus, 1 = hw
  logic [AW-1:0]       hold_addr;
  logic [DW-1:0]       hold_data;
  logic [DW-1:0]       hold_mask;
  logic                last_hw;    // last grant went to hw

  logic                grant_hw;
  logic                grant_bus;
  logic                accept;
  logic [DW-1:0]       q_sel;
  logic [NUM_REGS-1:0] sel_onehot;
  logic                addr_ok;
  logic                locked;
  logic                commit_err;

  function automatic logic [DW-1:0] masked_merge(input logic [DW-1:0] q,
                                                 input logic [DW-1:0] d,
                                                 input logic [DW-1:0] m);
    return (q & ~m) | (d & m);
  endfunction

  // ---- IDLE: round-robin grant ----
  // With both valid, the requester that was not granted last wins.
  assign grant_hw  = hw_valid && (!bus_valid || !last_hw);
  assign grant_bus = bus_valid && !grant_hw;
  // Gating with the reset net keeps ready low while reset is asserted.
  assign bus_ready = (state == IDLE) && reset && grant_bus;
  assign hw_ready  = (state == IDLE) && reset && grant_hw;
  assign accept    = bus_ready || hw_ready;

  // ---- COMMIT: decode target vector from the holding register ----
  always_comb begin
    q_sel      = '0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (hold_addr == AW'(i)) begin
        q_sel         = reg_q[i*DW +: DW];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  assign addr_ok = {1'b0, hold_addr} < NUM_REGS_W;

`ifdef UX607_REGVEC_LOCK_EN
  logic [NUM_REGS-1:0] lock_q;

  // Sticky locks; an out-of-range lock_addr matches no bit and is ignored.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lock_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (lock_set && (lock_addr == AW'(i))) lock_q[i] <= 1'b1;
      end
    end
  end

  // Only bus writes honour the lock.
  assign locked = !hold_src && |(lock_q & sel_onehot);
`else
  assign locked = 1'b0;
`endif

  assign commit_err = !addr_ok || locked;

  // Strobe and data come only from registered state, so en cannot glitch
  // outside COMMIT.
  assign reg_en = ((state == COMMIT) && !commit_err) ? sel_onehot : '0;
  assign reg_d  = (state == COMMIT) ? masked_merge(q_sel, hold_data, hold_mask) : '0;

  // ---- Scheduler FSM with registered status outputs ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      hold_src  <= 1'b0;
      hold_addr <= '0;
      hold_data <= '0;
      hold_mask <= '0;
      last_hw   <= 1'b1;
      done      <= 1'b0;
      done_src  <= 1'b0;
      done_err  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= COMMIT;
            busy      <= 1'b1;
            hold_src  <= grant_hw;
            last_hw   <= grant_hw;
            hold_addr <= grant_hw ? hw_addr : bus_addr;
            hold_data <= grant_hw ? hw_data : bus_data;
            hold_mask <= grant_hw ? {DW{1'b1}} : bus_mask;
          end
        end
        COMMIT: begin
          state    <= DONE;
          done     <= 1'b1;
          done_src <= hold_src;
          done_err <= commit_err;
        end
        DONE: begin
          state    <= IDLE;
          done     <= 1'b0;
          done_src <= 1'b0;
          done_err <= 1'b0;
          busy     <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          done     <= 1'b0;
          done_src <= 1'b0;
          done_err <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
